// File: rtl/boot_loader.sv
// boot_loader
//   Boot sequencer. On a start pulse it copies IMAGE_WORDS words from a
//   handshaked boot source into instruction memory through active-low
//   CS/WE/OE strobes. When VERIFY is set it reads back and compares each word.
//   The CPU is held in reset (cpu_reset_n=0) until the whole image is loaded.
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   start                one-cycle pulse, accepted only in IDLE/DONE/ERROR
//   src_req/src_addr     source request and word index (0..IMAGE_WORDS-1)
//   src_valid/src_data   source response, honoured in the same cycle
//   mem_addr/mem_wdata   memory address / write data
//   mem_rdata            memory read data, valid the cycle after oe_n low
//   mem_cs_n/we_n/oe_n   active-low memory strobes
//   busy/done/error      load status; done/error are sticky until start/reset
//   error_code/err_addr  01 verify mismatch, 10 source timeout; failing address
//   cpu_reset_n          control-unit reset, high only in DONE
//   dbg_state            current FSM state, for observation only
//
// Source handshake: while src_req is high the block holds src_addr stable and
// accepts the word on the first rising edge where src_valid is high; src_req
// drops on that same edge. src_valid is ignored while src_req is low.
module boot_loader #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    IMAGE_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    ADDR_STRIDE = 1,
    parameter int                    VERIFY      = 1,
    parameter int                    SRC_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  src_req,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs_n,
    output logic                  mem_we_n,
    output logic                  mem_oe_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  cpu_reset_n,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WRITE = 3'd2,
        S_VRD   = 3'd3,
        S_VCMP  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam int TCNT_W = (SRC_TIMEOUT > 1) ? $clog2(SRC_TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0]     TCNT_LAST = TCNT_W'(SRC_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(IMAGE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(ADDR_STRIDE);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [TCNT_W-1:0]     tcnt;
    // Running memory address of the current word; wraps naturally.
    logic [ADDR_WIDTH-1:0] addr_cur;

    assign src_addr  = idx;
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            tcnt        <= '0;
            addr_cur    <= BASE_ADDR;
            src_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_cs_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            mem_oe_n    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= 2'b00;
            err_addr    <= '0;
            cpu_reset_n <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state       <= S_FETCH;
                        idx         <= '0;
                        tcnt        <= '0;
                        addr_cur    <= BASE_ADDR;
                        src_req     <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        error_code  <= 2'b00;
                        err_addr    <= '0;
                        cpu_reset_n <= 1'b0;
                    end
                end

                S_FETCH: begin
                    // A word arriving on the last allowed cycle still wins
                    // over the timeout.
                    if (src_valid) begin
                        state     <= S_WRITE;
                        src_req   <= 1'b0;
                        mem_wdata <= src_data;
                        mem_addr  <= addr_cur;
                        mem_cs_n  <= 1'b0;
                        mem_we_n  <= 1'b0;
                    end else if (tcnt == TCNT_LAST) begin
                        state      <= S_ERROR;
                        src_req    <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        error_code <= 2'b10;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    mem_we_n <= 1'b1;
                    if (VERIFY != 0) begin
                        // Keep chip select low and turn straight into a read.
                        state    <= S_VRD;
                        mem_oe_n <= 1'b0;
                    end else begin
                        mem_cs_n <= 1'b1;
                        if (idx == IDX_LAST) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            idx      <= idx + 1'b1;
                            tcnt     <= '0;
                            addr_cur <= addr_cur + STRIDE;
                            src_req  <= 1'b1;
                        end
                    end
                end

                S_VRD: begin
                    state    <= S_VCMP;
                    mem_cs_n <= 1'b1;
                    mem_oe_n <= 1'b1;
                end

                S_VCMP: begin
                    // mem_wdata still holds the word that was just written.
                    if (mem_rdata != mem_wdata) begin
                        state      <= S_ERROR;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                        error_code <= 2'b01;
                        err_addr   <= mem_addr;
                    end else if (idx == IDX_LAST) begin
                        state       <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        cpu_reset_n <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        idx      <= idx + 1'b1;
                        tcnt     <= '0;
                        addr_cur <= addr_cur + STRIDE;
                        src_req  <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
//   Two boot_loader instances share clock and reset:
//     dut0: VERIFY=0, BASE_ADDR=0x000, ADDR_STRIDE=1, 4 words, SRC_TIMEOUT=8
//     dut1: VERIFY=1, BASE_ADDR=0x100, ADDR_STRIDE=4, 4 words, SRC_TIMEOUT=8
//   Each has its own boot source and memory model. When a load starts, the
//   bench turns the load plan (per-word source wait, image, corrupted word)
//   into the full expected per-cycle output trace; every falling edge pops
//   one expected vector and compares it with the DUT outputs.
module tb_boot_loader;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          error;
        logic [1:0]    code;
        logic [AW-1:0] err_addr;
        logic          cpu_rst_n;
        logic          src_req;
        logic [AW-1:0] src_addr;
        logic          cs_n;
        logic          we_n;
        logic          oe_n;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] wdata;
    } vec_t;

    // clock / reset
    logic clock;
    logic reset_n;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DUT signals, index = instance
    logic          start       [2];
    logic          src_req     [2];
    logic [AW-1:0] src_addr    [2];
    logic          src_valid   [2];
    logic [DW-1:0] src_data    [2];
    logic [AW-1:0] mem_addr    [2];
    logic [DW-1:0] mem_wdata   [2];
    logic [DW-1:0] mem_rdata   [2];
    logic          mem_cs_n    [2];
    logic          mem_we_n    [2];
    logic          mem_oe_n    [2];
    logic          busy        [2];
    logic          done        [2];
    logic          error       [2];
    logic [1:0]    error_code  [2];
    logic [AW-1:0] err_addr    [2];
    logic          cpu_reset_n [2];
    logic [2:0]    dbg_state   [2];

    boot_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMAGE_WORDS(N), .BASE_ADDR(16'h0000),
        .ADDR_STRIDE(1), .VERIFY(0), .SRC_TIMEOUT(TO)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]),
        .src_req(src_req[0]), .src_addr(src_addr[0]), .src_valid(src_valid[0]),
        .src_data(src_data[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_cs_n(mem_cs_n[0]), .mem_we_n(mem_we_n[0]),
        .mem_oe_n(mem_oe_n[0]), .busy(busy[0]), .done(done[0]), .error(error[0]),
        .error_code(error_code[0]), .err_addr(err_addr[0]),
        .cpu_reset_n(cpu_reset_n[0]), .dbg_state(dbg_state[0])
    );

    boot_loader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMAGE_WORDS(N), .BASE_ADDR(16'h0100),
        .ADDR_STRIDE(4), .VERIFY(1), .SRC_TIMEOUT(TO)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]),
        .src_req(src_req[1]), .src_addr(src_addr[1]), .src_valid(src_valid[1]),
        .src_data(src_data[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_cs_n(mem_cs_n[1]), .mem_we_n(mem_we_n[1]),
        .mem_oe_n(mem_oe_n[1]), .busy(busy[1]), .done(done[1]), .error(error[1]),
        .error_code(error_code[1]), .err_addr(err_addr[1]),
        .cpu_reset_n(cpu_reset_n[1]), .dbg_state(dbg_state[1])
    );

    function automatic int p_verify(int d); return (d == 1) ? 1 : 0; endfunction
    function automatic int p_base(int d);   return (d == 1) ? 'h100 : 0; endfunction
    function automatic int p_stride(int d); return (d == 1) ? 4 : 1; endfunction
    function automatic logic [AW-1:0] word_addr(int d, int k);
        return AW'(p_base(d) + k * p_stride(d));
    endfunction

    // load plan
    logic [DW-1:0] img [2][N];
    int            wt  [2][N];
    int            corrupt_k [2];
    int            scnt [2];

    // scoreboard
    vec_t exp_q [2][$];
    vec_t final_v [2];
    logic cur_busy [2];
    int   checks;
    int   fails;
    int   cyc;

    // memory models
    logic [DW-1:0] mem [int];
    logic [AW-1:0] wlog [2][16];
    int            wcnt [2] = '{0, 0};

    function automatic logic [DW-1:0] mem_rd(int key);
        return mem.exists(key) ? mem[key] : '0;
    endfunction

    always @(posedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!mem_cs_n[d] && !mem_we_n[d]) begin
                mem[d * 65536 + int'(mem_addr[d])] = mem_wdata[d];
                wlog[d][wcnt[d] % 16] = mem_addr[d];
                wcnt[d] = wcnt[d] + 1;
            end
            if (!mem_cs_n[d] && !mem_oe_n[d]) begin
                if (corrupt_k[d] >= 0 && mem_addr[d] == word_addr(d, corrupt_k[d]))
                    mem_rdata[d] <= mem_rd(d * 65536 + int'(mem_addr[d])) ^ 16'h0101;
                else
                    mem_rdata[d] <= mem_rd(d * 65536 + int'(mem_addr[d]));
            end
        end
    end

    // expected vectors
    function automatic vec_t idle_vec();
        vec_t v;
        v = '0;
        v.cs_n = 1'b1; v.we_n = 1'b1; v.oe_n = 1'b1;
        return v;
    endfunction

    function automatic vec_t busy_vec();
        vec_t v;
        v = idle_vec();
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic vec_t err_vec(logic [1:0] code, logic [AW-1:0] ea);
        vec_t v;
        v = idle_vec();
        v.error = 1'b1; v.code = code; v.err_addr = ea;
        return v;
    endfunction

    // Whole-load expectation: each word spends (wait+1) cycles in fetch unless
    // the wait reaches the timeout, then one write cycle, then read + compare
    // cycles when verifying.
    task automatic build_trace(int d);
        vec_t v;
        int   f;
        exp_q[d].delete();
        for (int k = 0; k < N; k++) begin
            f = (wt[d][k] < TO) ? wt[d][k] + 1 : TO;
            for (int i = 0; i < f; i++) begin
                v = busy_vec(); v.src_req = 1'b1; v.src_addr = AW'(k);
                exp_q[d].push_back(v);
            end
            if (wt[d][k] >= TO) begin
                final_v[d] = err_vec(2'b10, '0);
                return;
            end
            v = busy_vec(); v.cs_n = 1'b0; v.we_n = 1'b0;
            v.mem_addr = word_addr(d, k); v.wdata = img[d][k];
            exp_q[d].push_back(v);
            if (p_verify(d) != 0) begin
                v = busy_vec(); v.cs_n = 1'b0; v.oe_n = 1'b0; v.mem_addr = word_addr(d, k);
                exp_q[d].push_back(v);
                exp_q[d].push_back(busy_vec());
                if (corrupt_k[d] == k) begin
                    final_v[d] = err_vec(2'b01, word_addr(d, k));
                    return;
                end
            end
        end
        v = idle_vec(); v.done = 1'b1; v.cpu_rst_n = 1'b1;
        final_v[d] = v;
    endtask

    function automatic vec_t actual_vec(int d, vec_t e);
        vec_t a;
        a = '0;
        a.busy = busy[d]; a.done = done[d]; a.error = error[d];
        a.code = error_code[d]; a.err_addr = err_addr[d];
        a.cpu_rst_n = cpu_reset_n[d]; a.src_req = src_req[d];
        a.src_addr = e.src_req ? src_addr[d] : '0;
        a.cs_n = mem_cs_n[d]; a.we_n = mem_we_n[d]; a.oe_n = mem_oe_n[d];
        a.mem_addr = !e.cs_n ? mem_addr[d] : '0;
        a.wdata = !e.we_n ? mem_wdata[d] : '0;
        return a;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // driver: one cycle; compare on the falling edge, then drive inputs
    task automatic tick();
        vec_t e;
        vec_t a;
        @(negedge clock);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) e = exp_q[d].pop_front();
            else e = final_v[d];
            cur_busy[d] = e.busy;
            a = actual_vec(d, e);
            checks++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_vec dut%0d cyc=%0d got=%h expected=%h", d, cyc, a, e);
            end
        end
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            if (src_req[d] === 1'b1) begin
                int k;
                k = int'(src_addr[d]);
                if (k < N && scnt[d] == wt[d][k]) begin
                    src_valid[d] = 1'b1;
                    src_data[d]  = img[d][k];
                end else begin
                    src_valid[d] = 1'b0;
                    src_data[d]  = DW'($urandom);
                end
                scnt[d]++;
            end else begin
                scnt[d]      = 0;
                src_valid[d] = 1'b0;
            end
        end
    endtask

    // Call right after tick(); a start while the model is busy changes nothing.
    task automatic launch(int d);
        if (!cur_busy[d]) build_trace(d);
        start[d] = 1'b1;
    endtask

    task automatic run(input int poke_at, output int t0, output int t1);
        t0 = 0; t1 = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (t0 == 0 && (done[0] || error[0])) t0 = n;
            if (t1 == 0 && (done[1] || error[1])) t1 = n;
            if (n == poke_at) begin launch(0); launch(1); end
            if (!cur_busy[0] && !cur_busy[1] && t0 != 0 && t1 != 0) break;
        end
        chk("run_bound", {31'd0, (t0 != 0 && t1 != 0)}, 1);
    endtask

    function automatic int rand_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10) return 0;
        if (r < 16) return $urandom_range(1, 4);
        if (r < 18) return TO - 1;
        if (r == 18) return TO - 2;
        return 30;
    endfunction

    task automatic plan(int d, int w, int ck, logic [DW-1:0] base_val);
        for (int k = 0; k < N; k++) begin
            img[d][k] = base_val + DW'(k);
            wt[d][k]  = w;
        end
        corrupt_k[d] = ck;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            final_v[d]  = idle_vec();
            cur_busy[d] = 1'b0;
        end
    endtask

    initial begin
        int t0, t1, wb0, wb1, found;
        checks = 0; fails = 0; cyc = 0;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; src_valid[d] = 1'b0; src_data[d] = '0; scnt[d] = 0;
        end
        plan(0, 0, -1, 16'h0000);
        plan(1, 0, -1, 16'h0000);
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_state", {29'd0, dbg_state[0]}, 0);
        chk("rst_cs_n", {31'd0, mem_cs_n[1]}, 1);
        chk("rst_cpu_reset_n", {31'd0, cpu_reset_n[0]}, 0);

        // zero-wait copy without verify; 3-cycle source with strided addresses
        plan(0, 0, -1, 16'h00A0);
        plan(1, 3, -1, 16'h5A00);
        wb0 = wcnt[0]; wb1 = wcnt[1];
        launch(0); launch(1);
        run(0, t0, t1);
        chk("t1_done_cycle", t0, 9);
        chk("t1_cpu_reset_n", {31'd0, cpu_reset_n[0]}, 1);
        chk("t1_busy", {31'd0, busy[0]}, 0);
        chk("t1_nwrites", wcnt[0] - wb0, 4);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("t1_waddr%0d", k), {16'd0, wlog[0][(wb0 + k) % 16]}, k);
            chk($sformatf("t1_wdata%0d", k), {16'd0, mem_rd(k)}, 'hA0 + k);
            chk($sformatf("t6_waddr%0d", k), {16'd0, wlog[1][(wb1 + k) % 16]}, 'h100 + 4 * k);
        end
        chk("t6_done_cycle", t1, 29);

        // source timeout on dut0, readback mismatch of word 2 on dut1
        plan(0, 30, -1, 16'h1100);
        plan(1, 0, 2, 16'h2200);
        wb1 = wcnt[1];
        tick();
        launch(0); launch(1);
        run(0, t0, t1);
        chk("t3_err_cycle", t0, 9);
        chk("t3_code", {30'd0, error_code[0]}, 2);
        chk("t3_src_req", {31'd0, src_req[0]}, 0);
        chk("t3_cpu_reset_n", {31'd0, cpu_reset_n[0]}, 0);
        chk("t2_err_cycle", t1, 13);
        chk("t2_code", {30'd0, error_code[1]}, 1);
        chk("t2_err_addr", {16'd0, err_addr[1]}, 'h108);
        chk("t2_cpu_reset_n", {31'd0, cpu_reset_n[1]}, 0);
        chk("t2_nwrites", wcnt[1] - wb1, 3);

        // start while busy is ignored; start after DONE reloads
        plan(0, 0, -1, 16'h3300);
        plan(1, 0, -1, 16'h4400);
        tick();
        launch(0); launch(1);
        run(3, t0, t1);
        chk("t5_done_cycle0", t0, 9);
        chk("t5_done_cycle1", t1, 17);
        plan(0, 0, -1, 16'h3800);
        launch(0);
        tick();
        chk("t5_reload_done", {31'd0, done[0]}, 0);
        chk("t5_reload_cpu", {31'd0, cpu_reset_n[0]}, 0);
        run(0, t0, t1);
        chk("t5_reload_data", {16'd0, mem_rd(3)}, 'h3803);

        // a word arriving on the last permitted fetch cycle is still taken
        plan(0, 0, -1, 16'h6600);
        wt[0][0] = TO - 1; wt[0][2] = TO - 1;
        plan(1, 0, -1, 16'h7700);
        wt[1][0] = TO - 1; wt[1][1] = TO - 1;
        tick();
        launch(0); launch(1);
        run(0, t0, t1);
        chk("edge_done0", t0, 23);
        chk("edge_done1", t1, 31);
        chk("edge_flag0", {31'd0, done[0]}, 1);

        // asynchronous reset in the write cycle of word 1
        plan(0, 0, -1, 16'h8800);
        plan(1, 0, -1, 16'h9900);
        tick();
        launch(0); launch(1);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (mem_we_n[0] == 1'b0 && mem_addr[0] == 16'd1) found = 1;
        end
        chk("t4_reach_write1", found, 1);
        wb0 = wcnt[0];
        #2 reset_n = 1'b0;
        #1;
        chk("t4_cs_n_async", {31'd0, mem_cs_n[0]}, 1);
        chk("t4_we_n_async", {31'd0, mem_we_n[0]}, 1);
        chk("t4_busy_async", {31'd0, busy[0]}, 0);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("t4_state_idle", {29'd0, dbg_state[0]}, 0);
        chk("t4_no_partial_write", wcnt[0] - wb0, 0);

        // randomized loads
        for (int it = 0; it < 30; it++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < N; k++) begin
                    img[d][k] = DW'($urandom);
                    wt[d][k]  = rand_wait();
                end
                corrupt_k[d] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            end
            repeat ($urandom_range(1, 3)) tick();
            launch(0); launch(1);
            run(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0, t0, t1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
